// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer: state encoding,
// word size and the latched addressing-mode bundle.
package ldm_stm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_XFER,
        ST_WB,
        ST_DONE
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LIST_W     = 16;
    localparam int CNT_W      = 5;

    typedef struct packed {
        logic l;  // 1 = load, 0 = store
        logic p;  // pre-index
        logic u;  // up
        logic w;  // base writeback
    } xfer_mode_t;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Memory-side handshake of the block-transfer sequencer; the sequencer is the
// master, the memory system the slave.
interface ldm_stm_seq_if #(
    parameter int SIZE = 32
) ();

    logic            Mem_Req;
    logic            Mem_Write;
    logic [SIZE-1:0] Mem_Addr;
    logic [SIZE-1:0] Mem_WData;
    logic            Mem_Ready;
    logic [SIZE-1:0] Mem_RData;

    modport master (
        output Mem_Req, Mem_Write, Mem_Addr, Mem_WData,
        input  Mem_Ready, Mem_RData
    );

    modport slave (
        input  Mem_Req, Mem_Write, Mem_Addr, Mem_WData,
        output Mem_Ready, Mem_RData
    );

endinterface

// File: rtl/ldm_stm_seq_reg_list_scan.sv
// Combinational scan of a 16-bit register list: index of the lowest set bit
// (the next register to transfer) and the number of set bits.
module reg_list_scan
    import ldm_stm_pkg::*;
(
    input  logic [LIST_W-1:0] list,
    output logic [3:0]        low_idx,
    output logic [CNT_W-1:0]  count
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        low_idx = '0;
        count   = '0;
        // Walking downward lets the lowest set bit win the final assignment.
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list[i]) low_idx = 4'(i);
            count = count + CNT_W'(list[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// Sequencer for ARM-style LDM/STM block transfers: computes the address window,
// walks the register list one transfer per accepted beat, then writes back the base.
module ldm_stm_seq
    import ldm_stm_pkg::*;
#(
    parameter int ADDR = 4,
    parameter int SIZE = 32
) (
    input  logic               clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [LIST_W-1:0]  Reg_List,
    input  logic               L,
    input  logic               P,
    input  logic               U,
    input  logic               W,
    input  logic [ADDR-1:0]    Rn,
    input  logic [SIZE-1:0]    Base_Addr,
    input  logic [SIZE-1:0]    R_Data_C,
    ldm_stm_seq_if.master      mem,
    output logic [ADDR-1:0]    R_Addr_C,
    output logic               Write_Reg,
    output logic [ADDR-1:0]    W_Addr,
    output logic [SIZE-1:0]    W_Data,
    output logic               Write_PC,
    output logic [SIZE-1:0]    PC_New,
    output logic               Busy,
    output logic               Done,
    output logic               Err
);

    localparam logic [SIZE-1:0] WORD = SIZE'(WORD_BYTES);
    localparam logic [ADDR-1:0] PC_REG = ADDR'(15);

    state_t            state_q, state_d;
    logic [LIST_W-1:0] list_q;
    xfer_mode_t        mode_q;
    logic [ADDR-1:0]   rn_q;
    logic              rn_in_list_q;
    logic              err_q;
    logic [SIZE-1:0]   base_q;
    logic [SIZE-1:0]   addr_q;
    logic [SIZE-1:0]   final_q;

    logic [3:0]        cur_idx;
    logic [CNT_W-1:0]  count;
    logic [SIZE-1:0]   span;
    logic [SIZE-1:0]   start_addr;
    logic [SIZE-1:0]   final_base;

    reg_list_scan u_scan (
        .list    (list_q),
        .low_idx (cur_idx),
        .count   (count)
    );

    // Address window: lowest address first, whichever direction the base moves.
    assign span = SIZE'(count) * WORD;

    always_comb begin
        if (mode_q.u) start_addr = mode_q.p ? base_q + WORD : base_q;
        else          start_addr = mode_q.p ? base_q - span : base_q - span + WORD;
    end

    assign final_base = mode_q.u ? base_q + span : base_q - span;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (Start) state_d = ST_CALC;
            ST_CALC: state_d = (count == '0) ? ST_DONE : ST_XFER;
            ST_XFER: if (mem.Mem_Ready && count == CNT_W'(1)) state_d = ST_WB;
            ST_WB:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset clears the latched command too, so no stale list survives an abort.
    always_ff @(posedge clk) begin
        if (Rst) begin
            list_q       <= '0;
            mode_q       <= '0;
            rn_q         <= '0;
            rn_in_list_q <= 1'b0;
            err_q        <= 1'b0;
            base_q       <= '0;
            addr_q       <= '0;
            final_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (Start) begin
                    list_q       <= Reg_List;
                    mode_q       <= '{l: L, p: P, u: U, w: W};
                    rn_q         <= Rn;
                    rn_in_list_q <= Reg_List[Rn[3:0]];
                    base_q       <= Base_Addr;
                    err_q        <= 1'b0;
                end
                ST_CALC: begin
                    addr_q  <= start_addr;
                    final_q <= final_base;
                    err_q   <= (count == '0);
                end
                ST_XFER: if (mem.Mem_Ready) begin
                    list_q[cur_idx] <= 1'b0;
                    addr_q          <= addr_q + WORD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Busy           = (state_q != ST_IDLE);
        Done           = (state_q == ST_DONE);
        Err            = (state_q == ST_DONE) && err_q;
        mem.Mem_Req    = 1'b0;
        mem.Mem_Write  = 1'b0;
        mem.Mem_Addr   = '0;
        mem.Mem_WData  = '0;
        R_Addr_C       = '0;
        Write_Reg      = 1'b0;
        W_Addr         = '0;
        W_Data         = '0;
        Write_PC       = 1'b0;
        PC_New         = '0;
        case (state_q)
            ST_XFER: begin
                mem.Mem_Req   = 1'b1;
                mem.Mem_Write = ~mode_q.l;
                mem.Mem_Addr  = addr_q;
                if (!mode_q.l) begin
                    R_Addr_C      = ADDR'(cur_idx);
                    mem.Mem_WData = R_Data_C;
                end else if (mem.Mem_Ready) begin
                    // A load into R15 is a branch: it goes to the PC port instead.
                    if (cur_idx == 4'd15) begin
                        Write_PC = 1'b1;
                        PC_New   = mem.Mem_RData;
                    end else begin
                        Write_Reg = 1'b1;
                        W_Addr    = ADDR'(cur_idx);
                        W_Data    = mem.Mem_RData;
                    end
                end
            end
            ST_WB: begin
                // A loaded value of Rn wins over the written-back base.
                if (mode_q.w && !(mode_q.l && rn_in_list_q) && rn_q != PC_REG) begin
                    Write_Reg = 1'b1;
                    W_Addr    = rn_q;
                    W_Data    = final_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed table, multi-cycle corner
// sequences and randomized operations checked against a transaction-level model.
module tb_ldm_stm_seq;

    typedef struct packed {
        logic [15:0] list;
        logic        l;
        logic        p;
        logic        u;
        logic        w;
        logic [3:0]  rn;
        logic [31:0] base;
    } op_t;

    typedef struct {
        logic [31:0] first_addr;
        int          done_cyc;
        logic        err;
        logic        wb;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
    } obs_t;

    typedef struct {
        op_t         op;
        logic [31:0] first_addr;
        int          done_cyc;
        logic        err;
        logic        wb;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [15:0] Reg_List;
    logic        L, P, U, W;
    logic [3:0]  Rn;
    logic [31:0] Base_Addr;
    logic [31:0] R_Data_C;
    logic [3:0]  R_Addr_C;
    logic        Write_Reg;
    logic [3:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_PC;
    logic [31:0] PC_New;
    logic        Busy, Done, Err;

    int n_checks = 0;
    int n_errors = 0;

    ldm_stm_seq_if #(.SIZE(32)) mif ();

    ldm_stm_seq #(.ADDR(4), .SIZE(32)) dut (
        .clk       (clk),
        .Rst       (Rst),
        .Start     (Start),
        .Reg_List  (Reg_List),
        .L         (L),
        .P         (P),
        .U         (U),
        .W         (W),
        .Rn        (Rn),
        .Base_Addr (Base_Addr),
        .R_Data_C  (R_Data_C),
        .mem       (mif),
        .R_Addr_C  (R_Addr_C),
        .Write_Reg (Write_Reg),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .Write_PC  (Write_PC),
        .PC_New    (PC_New),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_word(input logic [3:0] r);
        return {16'hCAFE, 12'h000, r};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Register file read port: contents are a fixed function of the register number.
    assign R_Data_C = reg_word(R_Addr_C);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one operation to completion, checking every beat against the model.
    task automatic run_op(input op_t op, input int stall_pct, input int forced,
                          input bit hold, output obs_t ob);
        logic [31:0] exp_addr[$];
        logic [3:0]  exp_reg[$];
        logic [31:0] first, final_b;
        int n, xi, stalls, nwb, cyc, forced_left;
        bit exp_wb;

        n = 0;
        for (int k = 0; k < 16; k++) if (op.list[k]) n++;
        first   = op.u ? op.base + (op.p ? 32'd4 : 32'd0)
                       : op.base - 32'(4 * n) + (op.p ? 32'd0 : 32'd4);
        final_b = op.u ? op.base + 32'(4 * n) : op.base - 32'(4 * n);
        for (int k = 0; k < 16; k++) begin
            if (op.list[k]) begin
                exp_addr.push_back(first + 32'(4 * exp_addr.size()));
                exp_reg.push_back(4'(k));
            end
        end
        exp_wb = (n > 0) && op.w && !(op.l && op.list[op.rn]) && (op.rn != 4'd15);

        ob = '{first_addr: 32'h0, done_cyc: 0, err: 1'b0, wb: 1'b0, wb_addr: 4'h0, wb_data: 32'h0};
        xi = 0; stalls = 0; nwb = 0; cyc = 0; forced_left = forced;

        @(negedge clk);
        Start = 1'b1; Reg_List = op.list; L = op.l; P = op.p; U = op.u; W = op.w;
        Rn = op.rn; Base_Addr = op.base;

        while (ob.done_cyc == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (!hold) Start = 1'b0;
                Reg_List = 16'($urandom); Base_Addr = $urandom;
                {L, P, U, W} = 4'($urandom); Rn = 4'($urandom);
            end
            if (mif.Mem_Req) begin
                if (forced_left > 0) begin
                    mif.Mem_Ready = 1'b0;
                    forced_left--;
                end else begin
                    mif.Mem_Ready = ($urandom_range(99) >= stall_pct);
                end
                mif.Mem_RData = mem_word(mif.Mem_Addr);
            end else begin
                mif.Mem_Ready = (stall_pct == 0) ? 1'b1 : 1'($urandom);
                mif.Mem_RData = $urandom;
            end
            #1;
            check("busy_during_op", Busy, 1'b1);
            if (mif.Mem_Req) begin
                if (xi >= exp_addr.size()) begin
                    check("extra_xfer", 1'b1, 1'b0);
                end else begin
                    check("xfer_addr", mif.Mem_Addr, exp_addr[xi]);
                    check("xfer_write", mif.Mem_Write, !op.l);
                    if (!op.l) check("store_data", mif.Mem_WData, reg_word(exp_reg[xi]));
                    if (mif.Mem_Ready) begin
                        if (op.l && exp_reg[xi] == 4'd15) begin
                            check("pc_write", {Write_PC, Write_Reg}, 2'b10);
                            check("pc_new", PC_New, mem_word(exp_addr[xi]));
                        end else if (op.l) begin
                            check("load_write", {Write_Reg, Write_PC}, 2'b10);
                            check("load_waddr", W_Addr, exp_reg[xi]);
                            check("load_wdata", W_Data, mem_word(exp_addr[xi]));
                        end else begin
                            check("store_no_write", {Write_Reg, Write_PC}, 2'b00);
                        end
                        if (xi == 0) ob.first_addr = mif.Mem_Addr;
                        xi++;
                    end else begin
                        stalls++;
                        check("stall_no_write", {Write_Reg, Write_PC}, 2'b00);
                    end
                end
            end else begin
                check("no_pc_outside_xfer", Write_PC, 1'b0);
                if (Write_Reg) begin
                    nwb++;
                    ob.wb = 1'b1; ob.wb_addr = W_Addr; ob.wb_data = W_Data;
                end
                if (Done) begin
                    ob.done_cyc = cyc;
                    ob.err = Err;
                end else begin
                    check("err_only_with_done", Err, 1'b0);
                end
            end
        end

        if (ob.done_cyc == 0) check("done_timeout", 1'b0, 1'b1);
        check("xfer_count", xi, n);
        check("done_cycle", ob.done_cyc, (n == 0) ? 2 : n + 3 + stalls);
        check("err_flag", ob.err, n == 0);
        check("wb_count", nwb, exp_wb ? 1 : 0);
        if (exp_wb) begin
            check("wb_addr", ob.wb_addr, op.rn);
            check("wb_data", ob.wb_data, final_b);
        end

        // Cycle after Done: back in IDLE even if Start was still held high.
        @(negedge clk);
        #1;
        check("idle_after_done", {Busy, Done, mif.Mem_Req}, 3'b000);
        Start = 1'b0;
    endtask

    vec_t vecs[10];
    obs_t ob;
    op_t  op;

    initial begin
        vecs[0] = '{'{16'h000E, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  32'h0000_0100}, 32'h0000_0100, 6,  1'b0, 1'b1, 4'd0, 32'h0000_010C};
        vecs[1] = '{'{16'h8003, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5,  32'h0000_0200}, 32'h0000_01F4, 6,  1'b0, 1'b0, 4'd0, 32'h0};
        vecs[2] = '{'{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0000_0700}, 32'h0,          2,  1'b1, 1'b0, 4'd0, 32'h0};
        vecs[3] = '{'{16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2,  32'hFFFF_FFFC}, 32'h0000_0000, 4,  1'b0, 1'b1, 4'd2, 32'h0000_0000};
        vecs[4] = '{'{16'h00F0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  32'h0000_1000}, 32'h0000_0FF4, 7,  1'b0, 1'b1, 4'd1, 32'h0000_0FF0};
        vecs[5] = '{'{16'h0011, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4,  32'h0000_0040}, 32'h0000_0040, 5,  1'b0, 1'b0, 4'd0, 32'h0};
        vecs[6] = '{'{16'h0011, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  32'h0000_0040}, 32'h0000_0040, 5,  1'b0, 1'b1, 4'd4, 32'h0000_0048};
        vecs[7] = '{'{16'h0003, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 32'h0000_0080}, 32'h0000_0084, 5,  1'b0, 1'b0, 4'd0, 32'h0};
        vecs[8] = '{'{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3,  32'h0000_0000}, 32'h0000_0000, 19, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[9] = '{'{16'h0C00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6,  32'h0000_2000}, 32'h0000_1FF8, 5,  1'b0, 1'b1, 4'd6, 32'h0000_1FF8};

        Rst = 1'b1; Start = 1'b0; Reg_List = '0; {L, P, U, W} = 4'b0; Rn = '0; Base_Addr = '0;
        mif.Mem_Ready = 1'b1; mif.Mem_RData = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_ctl", {Busy, Done, Err, mif.Mem_Req, mif.Mem_Write, Write_Reg, Write_PC}, 7'b0);
        check("reset_data", {mif.Mem_Addr, mif.Mem_WData, W_Data, PC_New}, 128'h0);
        check("reset_addrs", {W_Addr, R_Addr_C}, 8'h0);
        Rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, 0, 0, 1'b0, ob);
            check($sformatf("vec%0d_first_addr", i), ob.first_addr, vecs[i].first_addr);
            check($sformatf("vec%0d_done_cycle", i), ob.done_cyc, vecs[i].done_cyc);
            check($sformatf("vec%0d_err", i), ob.err, vecs[i].err);
            check($sformatf("vec%0d_wb", i), ob.wb, vecs[i].wb);
            if (vecs[i].wb) begin
                check($sformatf("vec%0d_wb_addr", i), ob.wb_addr, vecs[i].wb_addr);
                check($sformatf("vec%0d_wb_data", i), ob.wb_data, vecs[i].wb_data);
            end
        end

        // Load of the base register with three wait cycles before acceptance.
        run_op('{16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h0000_0300}, 0, 3, 1'b0, ob);
        check("stall_done_cycle", ob.done_cyc, 7);
        check("stall_wb_suppressed", ob.wb, 1'b0);

        // Start held high through the whole operation and its Done cycle.
        run_op('{16'h0104, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0000_0080}, 0, 0, 1'b1, ob);
        check("hold_start_done_cycle", ob.done_cyc, 5);

        // Reset after the first of four store beats.
        @(negedge clk);
        Start = 1'b1; Reg_List = 16'h000F; {L, P, U, W} = 4'b0011; Rn = 4'd8;
        Base_Addr = 32'h0000_0500; mif.Mem_Ready = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        mif.Mem_Ready = 1'b1;
        #1;
        check("rst_mid_beat0_addr", mif.Mem_Addr, 32'h0000_0500);
        @(negedge clk);
        mif.Mem_Ready = 1'b0; Rst = 1'b1;
        #1;
        check("rst_mid_beat1_addr", {mif.Mem_Req, mif.Mem_Addr}, {1'b1, 32'h0000_0504});
        @(negedge clk);
        Rst = 1'b0;
        #1;
        check("rst_mid_idle", {Busy, Done, mif.Mem_Req, Write_Reg}, 4'b0000);
        check("rst_mid_addr_clear", mif.Mem_Addr, 32'h0);
        @(negedge clk);
        #1;
        check("rst_mid_stays_idle", Busy, 1'b0);
        run_op('{16'h000F, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 32'h0000_0500}, 0, 0, 1'b0, ob);
        check("rst_mid_rerun_done", ob.done_cyc, 7);

        // Reset and Start in the same cycle: reset wins.
        @(negedge clk);
        Start = 1'b1; Rst = 1'b1; Reg_List = 16'h0003;
        @(negedge clk);
        Start = 1'b0; Rst = 1'b0;
        #1;
        check("rst_over_start", Busy, 1'b0);
        @(negedge clk);
        #1;
        check("rst_over_start_idle", Busy, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0:       op.list = 16'h0;
                1:       op.list = 16'($urandom) & 16'($urandom);
                2:       op.list = 16'($urandom) | 16'($urandom);
                default: op.list = 16'($urandom);
            endcase
            {op.l, op.p, op.u, op.w} = 4'($urandom);
            op.rn   = 4'($urandom);
            op.base = $urandom;
            run_op(op, ($urandom_range(2) == 0) ? 0 : int'($urandom_range(60)),
                   int'($urandom_range(2)), ($urandom_range(3) == 0), ob);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
